// File: rtl/bp_update_queue.sv
// Predictor update queue: buffers branch resolutions and drains one per cycle to the BHT/BTB.
// Optional feature macro BP_UPDATE_COALESCE_EN: a push matching the tail pc overwrites the tail in place.
package bp_update_pkg;
    localparam int unsigned VLEN = 32;

    typedef enum logic [2:0] {NoCF, Branch, Jump, JumpR, Return} cf_t;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target_address;
        logic            is_mispredict;
        logic            is_taken;
        cf_t             cf_type;
    } bp_resolve_t;
endpackage

module bp_update_queue #(
    parameter type         bp_resolve_t = bp_update_pkg::bp_resolve_t,
    parameter int unsigned DEPTH        = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  bp_resolve_t resolved_branch_i,
    input  logic        flush_i,
    output bp_resolve_t update_o,
    output logic        update_valid_o,
    input  logic        update_ready_i,
    output logic        full_o,
    output logic [7:0]  drop_cnt_o
);
    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam int unsigned   CW       = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    bp_resolve_t   mem   [DEPTH];
    bp_resolve_t   mem_n [DEPTH];
    bp_resolve_t   head_entry;
    logic [PW-1:0] head, tail, head_n, tail_n, tail_last;
    logic [CW-1:0] count, count_n;
    logic [7:0]    drop_n;
    logic          push, pop, coalesce;

    assign push = resolved_branch_i.valid &&
                  (resolved_branch_i.cf_type == bp_update_pkg::Branch || resolved_branch_i.is_mispredict);
    assign pop       = update_valid_o && update_ready_i && !flush_i;
    assign tail_last = tail - PTR_ONE;

`ifdef BP_UPDATE_COALESCE_EN
    // The tail may only be rewritten if it is not leaving the queue this cycle.
    assign coalesce = push && !flush_i && (count != '0) &&
                      (mem[tail_last].pc == resolved_branch_i.pc) &&
                      !(count == CNT_ONE && pop);
`else
    assign coalesce = 1'b0;
`endif

    always_comb begin
        mem_n   = mem;
        head_n  = head;
        tail_n  = tail;
        count_n = count;
        drop_n  = drop_cnt_o;
        if (flush_i) begin
            head_n  = tail;
            count_n = '0;
            if (push) begin
                mem_n[tail] = resolved_branch_i;
                tail_n      = tail + PTR_ONE;
                count_n     = CNT_ONE;
            end
        end else if (coalesce) begin
            mem_n[tail_last] = resolved_branch_i;
            if (pop) begin
                head_n  = head + PTR_ONE;
                count_n = count - CNT_ONE;
            end
        end else if (push && pop) begin
            mem_n[tail] = resolved_branch_i;
            tail_n      = tail + PTR_ONE;
            head_n      = head + PTR_ONE;
        end else if (push && count == FULL_CNT) begin
            // When full, tail == head: a mispredict replaces the oldest entry.
            if (resolved_branch_i.is_mispredict) begin
                mem_n[tail] = resolved_branch_i;
                tail_n      = tail + PTR_ONE;
                head_n      = head + PTR_ONE;
            end
            if (drop_cnt_o != 8'hFF) drop_n = drop_cnt_o + 8'd1;
        end else if (push) begin
            mem_n[tail] = resolved_branch_i;
            tail_n      = tail + PTR_ONE;
            count_n     = count + CNT_ONE;
        end else if (pop) begin
            head_n  = head + PTR_ONE;
            count_n = count - CNT_ONE;
        end
        head_entry       = mem_n[head_n];
        head_entry.valid = (count_n != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            drop_cnt_o     <= '0;
            update_o       <= '0;
            update_valid_o <= 1'b0;
            full_o         <= 1'b0;
        end else begin
            head           <= head_n;
            tail           <= tail_n;
            count          <= count_n;
            drop_cnt_o     <= drop_n;
            update_o       <= head_entry;
            update_valid_o <= (count_n != '0);
            full_o         <= (count_n == FULL_CNT);
        end
    end

    always_ff @(posedge clk_i) begin
        mem <= mem_n;
    end
endmodule

// File: tb/tb_bp_update_queue.sv
// Directed table-driven bench for bp_update_queue (DEPTH=4), plus hand sequences
// for drop-counter saturation and reset mid-drain.
module tb_bp_update_queue;
    import bp_update_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    bp_resolve_t rb;
    logic        flush;
    bp_resolve_t upd;
    logic        upd_valid;
    logic        ready;
    logic        full;
    logic [7:0]  drop;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bp_update_queue #(.DEPTH(4)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .resolved_branch_i(rb),
        .flush_i          (flush),
        .update_o         (upd),
        .update_valid_o   (upd_valid),
        .update_ready_i   (ready),
        .full_o           (full),
        .drop_cnt_o       (drop)
    );

    typedef struct {
        logic        rst_n;
        logic        v;
        cf_t         cf;
        logic        misp;
        logic        taken;
        logic [31:0] pc;
        logic        flush;
        logic        ready;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_taken;
        logic        e_full;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic v, cf_t cf, logic misp, logic taken, logic [31:0] pc,
                                logic fl, logic rdy, logic ev, logic [31:0] epc, logic et,
                                logic ef, logic [7:0] ed);
        vec_t x;
        x.rst_n = r; x.v = v; x.cf = cf; x.misp = misp; x.taken = taken; x.pc = pc;
        x.flush = fl; x.ready = rdy; x.e_valid = ev; x.e_pc = epc; x.e_taken = et;
        x.e_full = ef; x.e_drop = ed;
        return x;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(logic r, logic v, cf_t cf, logic misp, logic taken, logic [31:0] pc,
                         logic fl, logic rdy);
        rst_n            = r;
        rb               = '0;
        rb.valid         = v;
        rb.cf_type       = cf;
        rb.is_mispredict = misp;
        rb.is_taken      = taken;
        rb.pc            = pc;
        rb.target_address = pc + 32'd4;
        flush            = fl;
        ready            = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, NoCF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        step();
        step();
        chk("reset_valid", upd_valid, 0);
        chk("reset_update", upd, 0);
        chk("reset_full", full, 0);
        chk("reset_drop", drop, 0);

        // Single push, hold while stalled, then pop.
        vecs.push_back(mk(1,1,Branch,0,1,32'h80, 0,0, 1,32'h80,1,0,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1,0,NoCF,0,0,32'h0, 0,0, 1,32'h80,1,0,0));
        vecs.push_back(mk(1,0,NoCF,0,0,32'h0, 0,1, 0,32'h0,0,0,0));
        // Fill to full, drop a correct prediction, overwrite with a mispredict.
        vecs.push_back(mk(1,1,Branch,0,1,32'h100, 0,0, 1,32'h100,1,0,0));
        vecs.push_back(mk(1,1,Branch,0,1,32'h110, 0,0, 1,32'h100,1,0,0));
        vecs.push_back(mk(1,1,Branch,0,1,32'h120, 0,0, 1,32'h100,1,0,0));
        vecs.push_back(mk(1,1,Branch,0,1,32'h130, 0,0, 1,32'h100,1,1,0));
        vecs.push_back(mk(1,1,Branch,0,1,32'h140, 0,0, 1,32'h100,1,1,1));
        vecs.push_back(mk(1,1,Branch,1,1,32'h200, 0,0, 1,32'h110,1,1,2));
        // Push and pop together while full, then drain to confirm order.
        vecs.push_back(mk(1,1,Branch,0,1,32'h210, 0,1, 1,32'h120,1,1,2));
        vecs.push_back(mk(1,0,NoCF,0,0,32'h0, 0,1, 1,32'h130,1,0,2));
        vecs.push_back(mk(1,0,NoCF,0,0,32'h0, 0,1, 1,32'h200,1,0,2));
        vecs.push_back(mk(1,0,NoCF,0,0,32'h0, 0,1, 1,32'h210,1,0,2));
        vecs.push_back(mk(1,0,NoCF,0,0,32'h0, 0,1, 0,32'h0,0,0,2));
        // Correct jump is ignored; mispredicted jump is queued.
        vecs.push_back(mk(1,1,Jump,0,1,32'h500, 0,0, 0,32'h0,0,0,2));
        vecs.push_back(mk(1,1,Jump,1,1,32'h510, 0,0, 1,32'h510,1,0,2));
        vecs.push_back(mk(1,1,Branch,0,1,32'h520, 0,0, 1,32'h510,1,0,2));
        vecs.push_back(mk(1,1,Branch,0,1,32'h530, 0,0, 1,32'h510,1,0,2));
        // Flush with a push (and a would-be pop): single entry remains.
        vecs.push_back(mk(1,1,Branch,1,1,32'h300, 1,1, 1,32'h300,1,0,2));
        vecs.push_back(mk(1,0,NoCF,0,0,32'h0, 0,1, 0,32'h0,0,0,2));
        // Flush alone empties the queue.
        vecs.push_back(mk(1,1,Branch,0,1,32'h600, 0,0, 1,32'h600,1,0,2));
        vecs.push_back(mk(1,0,NoCF,0,0,32'h0, 1,0, 0,32'h0,0,0,2));
        // Same pc twice.
        vecs.push_back(mk(1,1,Branch,0,1,32'h400, 0,0, 1,32'h400,1,0,2));
`ifdef BP_UPDATE_COALESCE_EN
        vecs.push_back(mk(1,1,Branch,0,0,32'h400, 0,0, 1,32'h400,0,0,2));
        vecs.push_back(mk(1,0,NoCF,0,0,32'h0, 0,1, 0,32'h0,0,0,2));
`else
        vecs.push_back(mk(1,1,Branch,0,0,32'h400, 0,0, 1,32'h400,1,0,2));
        vecs.push_back(mk(1,0,NoCF,0,0,32'h0, 0,1, 1,32'h400,0,0,2));
`endif
        vecs.push_back(mk(1,0,NoCF,0,0,32'h0, 0,1, 0,32'h0,0,0,2));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].v, vecs[i].cf, vecs[i].misp, vecs[i].taken,
                  vecs[i].pc, vecs[i].flush, vecs[i].ready);
            step();
            chk($sformatf("v%0d_valid", i), upd_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_upd_valid_field", i), upd.valid, vecs[i].e_valid);
            chk($sformatf("v%0d_full", i), full, vecs[i].e_full);
            chk($sformatf("v%0d_drop", i), drop, vecs[i].e_drop);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_pc", i), upd.pc, vecs[i].e_pc);
                chk($sformatf("v%0d_taken", i), upd.is_taken, vecs[i].e_taken);
            end
        end

        // Drop counter saturation: fill, then keep pushing correct branches.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, Branch, 0, 1, 32'h700 + i, 0, 0);
            step();
        end
        chk("sat_full", full, 1);
        for (int i = 0; i < 253; i++) begin
            drive(1, 1, Branch, 0, 1, 32'h800 + 4 * i, 0, 0);
            step();
        end
        chk("sat_drop_ff", drop, 8'hFF);
        for (int i = 0; i < 47; i++) begin
            drive(1, 1, Branch, 0, 1, 32'hA00 + 4 * i, 0, 0);
            step();
        end
        chk("sat_drop_hold", drop, 8'hFF);
        chk("sat_head_pc", upd.pc, 32'h700);

        // Reset mid-drain.
        drive(0, 1, Branch, 1, 1, 32'hB00, 0, 1);
        step();
        chk("rst_mid_valid", upd_valid, 0);
        chk("rst_mid_update", upd, 0);
        chk("rst_mid_full", full, 0);
        chk("rst_mid_drop", drop, 0);

        // Queue works again after reset; pop on the first visible cycle.
        drive(1, 1, Branch, 0, 1, 32'h900, 0, 0);
        step();
        chk("post_rst_valid", upd_valid, 1);
        chk("post_rst_pc", upd.pc, 32'h900);
        drive(1, 0, NoCF, 0, 0, 32'h0, 0, 1);
        step();
        chk("post_rst_pop", upd_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
